// File: rtl/md_sequencer.sv
// md_sequencer
//
// Multicycle sequencer for the multiply/divide resource. A one-cycle launch
// request from the main control unit starts a mult, a div, or (optionally) a
// divm with both operands fetched from memory. The block drives the Mult/Div
// unit enables, the Div operand-select muxes, the Hi/Lo source mux and write
// enables, and the memory address mux ownership during a divm fetch. It
// reports completion (done) or divide-by-zero (div0_excpt) and holds busy
// high for the whole operation.
//
// Optional feature macro: MD_DIVM_EN
//   defined   -> divm fetch states exist and op_sel 2'b10 runs divm.
//   undefined -> op_sel 2'b10 is ignored like 2'b11, and mem_own,
//                mem_addr_sel, mdr_write, div_a_sel, div_b_sel are tied to 0.
//
// Parameters:
//   MULT_CYCLES  cycles mult_ctrl is held before writeback (>= 1)
//   DIV_CYCLES   cycles the divider runs after operand load (>= 1)
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high
//   op_start      launch pulse, sampled only in IDLE
//   op_sel        00 mult, 01 div, 10 divm, 11 reserved
//   divisor_zero  divider B input (post-mux) is zero
//   busy          state is not IDLE
//   done          one-cycle pulse in writeback
//   div0_excpt    one-cycle pulse on divide-by-zero
//   mult_ctrl     Mult unit run enable
//   div_a_write   Div operand A write enable
//   div_b_write   Div operand B write enable
//   div_a_sel     Div operand A select (0 A_Out, 1 MDR)
//   div_b_sel     Div operand B select (0 B_Out, 1 MDR)
//   md_select     Hi/Lo source select (0 Div, 1 Mult)
//   hi_write      Hi register write enable
//   lo_write      Lo register write enable
//   mem_own       this block owns the memory address mux
//   mem_addr_sel  memory address source (0 A_Out, 1 B_Out)
//   mdr_write     MDR write enable
//
// All outputs are registered copies of the next-state decode, so each output
// is a pure function of the current state.

module md_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_start,
    input  logic [1:0] op_sel,
    input  logic       divisor_zero,
    output logic       busy,
    output logic       done,
    output logic       div0_excpt,
    output logic       mult_ctrl,
    output logic       div_a_write,
    output logic       div_b_write,
    output logic       div_a_sel,
    output logic       div_b_sel,
    output logic       md_select,
    output logic       hi_write,
    output logic       lo_write,
    output logic       mem_own,
    output logic       mem_addr_sel,
    output logic       mdr_write
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Keep at least one counter bit so a 1-cycle configuration still elaborates.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
`ifdef MD_DIVM_EN
    localparam logic [1:0] OP_DIVM = 2'b10;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_MULT_RUN,
        S_DIV_LOAD,
`ifdef MD_DIVM_EN
        S_RDA_ADDR,
        S_RDA_WAIT,
        S_LOADA,
        S_RDB_ADDR,
        S_RDB_WAIT,
        S_LOADB,
`endif
        S_DIV_RUN,
        S_WB,
        S_EXC
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic div0_excpt_q, div0_excpt_d;
    logic mult_ctrl_q, mult_ctrl_d;
    logic div_a_write_q, div_a_write_d;
    logic div_b_write_q, div_b_write_d;
    logic md_select_q, md_select_d;
    logic hi_write_q, hi_write_d;
    logic lo_write_q, lo_write_d;
`ifdef MD_DIVM_EN
    logic div_a_sel_q, div_a_sel_d;
    logic div_b_sel_q, div_b_sel_d;
    logic mem_own_q, mem_own_d;
    logic mem_addr_sel_q, mem_addr_sel_d;
    logic mdr_write_q, mdr_write_d;
`endif

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    case (op_sel)
                        OP_MULT: begin
                            state_d = S_MULT_RUN;
                            cnt_d   = MULT_LOAD;
                            op_d    = op_sel;
                        end
                        OP_DIV: begin
                            state_d = S_DIV_LOAD;
                            op_d    = op_sel;
                        end
`ifdef MD_DIVM_EN
                        OP_DIVM: begin
                            state_d = S_RDA_ADDR;
                            op_d    = op_sel;
                        end
`endif
                        default: ; // reserved selects are ignored
                    endcase
                end
            end
            S_MULT_RUN: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DIV_LOAD: begin
                if (divisor_zero) begin
                    state_d = S_EXC;
                end else begin
                    state_d = S_DIV_RUN;
                    cnt_d   = DIV_LOAD;
                end
            end
`ifdef MD_DIVM_EN
            // Memory reads are synchronous, so each operand needs an address
            // cycle, a wait cycle that captures MDR, and a load cycle.
            S_RDA_ADDR: state_d = S_RDA_WAIT;
            S_RDA_WAIT: state_d = S_LOADA;
            S_LOADA:    state_d = S_RDB_ADDR;
            S_RDB_ADDR: state_d = S_RDB_WAIT;
            S_RDB_WAIT: state_d = S_LOADB;
            S_LOADB: begin
                if (divisor_zero) begin
                    state_d = S_EXC;
                end else begin
                    state_d = S_DIV_RUN;
                    cnt_d   = DIV_LOAD;
                end
            end
`endif
            S_DIV_RUN: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_WB:    state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state; registered below so outputs track
    // the state register exactly.
    always_comb begin
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_WB);
        div0_excpt_d  = (state_d == S_EXC);
        mult_ctrl_d   = (state_d == S_MULT_RUN);
        hi_write_d    = (state_d == S_WB);
        lo_write_d    = (state_d == S_WB);
        md_select_d   = (state_d == S_WB) && (op_d == OP_MULT);
        div_a_write_d = (state_d == S_DIV_LOAD);
        div_b_write_d = (state_d == S_DIV_LOAD);
`ifdef MD_DIVM_EN
        div_a_write_d  = div_a_write_d || (state_d == S_LOADA);
        div_b_write_d  = div_b_write_d || (state_d == S_LOADB);
        div_a_sel_d    = (state_d == S_LOADA);
        div_b_sel_d    = (state_d == S_LOADB);
        mem_own_d      = (state_d == S_RDA_ADDR) || (state_d == S_RDA_WAIT) ||
                         (state_d == S_RDB_ADDR) || (state_d == S_RDB_WAIT);
        mem_addr_sel_d = (state_d == S_RDB_ADDR) || (state_d == S_RDB_WAIT);
        mdr_write_d    = (state_d == S_RDA_WAIT) || (state_d == S_RDB_WAIT);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div0_excpt_q   <= 1'b0;
            mult_ctrl_q    <= 1'b0;
            div_a_write_q  <= 1'b0;
            div_b_write_q  <= 1'b0;
            md_select_q    <= 1'b0;
            hi_write_q     <= 1'b0;
            lo_write_q     <= 1'b0;
`ifdef MD_DIVM_EN
            div_a_sel_q    <= 1'b0;
            div_b_sel_q    <= 1'b0;
            mem_own_q      <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            mdr_write_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            div0_excpt_q   <= div0_excpt_d;
            mult_ctrl_q    <= mult_ctrl_d;
            div_a_write_q  <= div_a_write_d;
            div_b_write_q  <= div_b_write_d;
            md_select_q    <= md_select_d;
            hi_write_q     <= hi_write_d;
            lo_write_q     <= lo_write_d;
`ifdef MD_DIVM_EN
            div_a_sel_q    <= div_a_sel_d;
            div_b_sel_q    <= div_b_sel_d;
            mem_own_q      <= mem_own_d;
            mem_addr_sel_q <= mem_addr_sel_d;
            mdr_write_q    <= mdr_write_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign div0_excpt   = div0_excpt_q;
    assign mult_ctrl    = mult_ctrl_q;
    assign div_a_write  = div_a_write_q;
    assign div_b_write  = div_b_write_q;
    assign md_select    = md_select_q;
    assign hi_write     = hi_write_q;
    assign lo_write     = lo_write_q;
`ifdef MD_DIVM_EN
    assign div_a_sel    = div_a_sel_q;
    assign div_b_sel    = div_b_sel_q;
    assign mem_own      = mem_own_q;
    assign mem_addr_sel = mem_addr_sel_q;
    assign mdr_write    = mdr_write_q;
`else
    assign div_a_sel    = 1'b0;
    assign div_b_sel    = 1'b0;
    assign mem_own      = 1'b0;
    assign mem_addr_sel = 1'b0;
    assign mdr_write    = 1'b0;
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// Directed testbench for md_sequencer with default parameters (32/32).
// Outputs are sampled on the falling edge; cycle k after a launch is the k-th
// falling edge after the rising edge that accepted op_start.

module tb_md_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_start;
    logic [1:0] op_sel;
    logic       divisor_zero;
    logic       busy, done, div0_excpt, mult_ctrl;
    logic       div_a_write, div_b_write, div_a_sel, div_b_sel;
    logic       md_select, hi_write, lo_write;
    logic       mem_own, mem_addr_sel, mdr_write;

    int n_checks = 0;
    int n_pass   = 0;

    // Output bit positions within the packed observation vector.
    localparam int O_BUSY = 13, O_DONE = 12, O_DIV0 = 11, O_MULT = 10;
    localparam int O_DAW  = 9,  O_DBW  = 8,  O_DAS  = 7,  O_DBS  = 6;
    localparam int O_MDS  = 5,  O_HI   = 4,  O_LO   = 3,  O_MOWN = 2;
    localparam int O_MSEL = 1,  O_MDR  = 0;

    logic [13:0] outs;
    assign outs = {busy, done, div0_excpt, mult_ctrl, div_a_write, div_b_write,
                   div_a_sel, div_b_sel, md_select, hi_write, lo_write,
                   mem_own, mem_addr_sel, mdr_write};

    md_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_sel       (op_sel),
        .divisor_zero (divisor_zero),
        .busy         (busy),
        .done         (done),
        .div0_excpt   (div0_excpt),
        .mult_ctrl    (mult_ctrl),
        .div_a_write  (div_a_write),
        .div_b_write  (div_b_write),
        .div_a_sel    (div_a_sel),
        .div_b_sel    (div_b_sel),
        .md_select    (md_select),
        .hi_write     (hi_write),
        .lo_write     (lo_write),
        .mem_own      (mem_own),
        .mem_addr_sel (mem_addr_sel),
        .mdr_write    (mdr_write)
    );

    always #5 clk = ~clk;

    // Drive a one-cycle launch; returns just after the accepting edge.
    task automatic launch(input logic [1:0] sel);
        @(negedge clk);
        op_start = 1'b1;
        op_sel   = sel;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; op_start = 1'b0; op_sel = 2'b00; divisor_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (outs !== 14'b0) $display("FAIL reset_outs got=%b exp=%b", outs, 14'b0);
        else n_pass++;
        // reset together with a launch: reset wins, op is not accepted
        op_start = 1'b1; op_sel = 2'b00;
        @(negedge clk);
        n_checks++;
        if (outs !== 14'b0) $display("FAIL reset_with_start got=%b exp=%b", outs, 14'b0);
        else n_pass++;
        reset = 1'b0; op_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 14'b0) $display("FAIL reset_start_not_queued cyc=%0d got=%b exp=%b", k, outs, 14'b0);
            else n_pass++;
        end
    endtask

    // mult with ignored launches in cycle 5 (MULT_RUN) and cycle 33 (WB)
    task automatic test_mult;
        logic [13:0] e;
        launch(2'b00);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            e = '0;
            if (k <= 32) begin
                e[O_BUSY] = 1'b1; e[O_MULT] = 1'b1;
            end else if (k == 33) begin
                e[O_BUSY] = 1'b1; e[O_DONE] = 1'b1; e[O_MDS] = 1'b1;
                e[O_HI] = 1'b1; e[O_LO] = 1'b1;
            end
            n_checks++;
            if (outs !== e) $display("FAIL mult cyc=%0d got=%b exp=%b", k, outs, e);
            else n_pass++;
            op_start = (k == 5 || k == 33);
            op_sel   = 2'b00;
        end
        op_start = 1'b0;
    endtask

    task automatic test_div;
        logic [13:0] e;
        divisor_zero = 1'b0;
        launch(2'b01);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            e = '0;
            if (k <= 34) e[O_BUSY] = 1'b1;
            if (k == 1) begin
                e[O_DAW] = 1'b1; e[O_DBW] = 1'b1;
            end
            if (k == 34) begin
                e[O_DONE] = 1'b1; e[O_HI] = 1'b1; e[O_LO] = 1'b1;
            end
            n_checks++;
            if (outs !== e) $display("FAIL div cyc=%0d got=%b exp=%b", k, outs, e);
            else n_pass++;
        end
    endtask

    task automatic test_div0;
        logic [13:0] e;
        divisor_zero = 1'b1;
        launch(2'b01);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            e = '0;
            if (k == 1) begin
                e[O_BUSY] = 1'b1; e[O_DAW] = 1'b1; e[O_DBW] = 1'b1;
            end
            if (k == 2) begin
                e[O_BUSY] = 1'b1; e[O_DIV0] = 1'b1;
            end
            n_checks++;
            if (outs !== e) $display("FAIL div0 cyc=%0d got=%b exp=%b", k, outs, e);
            else n_pass++;
        end
        divisor_zero = 1'b0;
    endtask

    task automatic test_reserved(input logic [1:0] sel);
        launch(sel);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 14'b0) $display("FAIL reserved sel=%b cyc=%0d got=%b exp=%b", sel, k, outs, 14'b0);
            else n_pass++;
        end
    endtask

`ifdef MD_DIVM_EN
    task automatic test_divm(input logic dz);
        logic [13:0] e;
        int last;
        divisor_zero = dz;
        last = dz ? 8 : 40;
        launch(2'b10);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            e = '0;
            e[O_BUSY] = (k < last);
            case (k)
                1: e[O_MOWN] = 1'b1;
                2: begin e[O_MOWN] = 1'b1; e[O_MDR] = 1'b1; end
                3: begin e[O_DAW] = 1'b1; e[O_DAS] = 1'b1; end
                4: begin e[O_MOWN] = 1'b1; e[O_MSEL] = 1'b1; end
                5: begin e[O_MOWN] = 1'b1; e[O_MSEL] = 1'b1; e[O_MDR] = 1'b1; end
                6: begin e[O_DBW] = 1'b1; e[O_DBS] = 1'b1; end
                default: ;
            endcase
            if (dz && k == 7) e[O_DIV0] = 1'b1;
            if (!dz && k == 39) begin
                e[O_DONE] = 1'b1; e[O_HI] = 1'b1; e[O_LO] = 1'b1;
            end
            n_checks++;
            if (outs !== e) $display("FAIL divm dz=%0b cyc=%0d got=%b exp=%b", dz, k, outs, e);
            else n_pass++;
        end
        divisor_zero = 1'b0;
    endtask
`endif

    // reset asserted in cycle 10 of a mult, then a fresh div
    task automatic test_reset_mid;
        logic [13:0] e;
        launch(2'b00);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e = '0; e[O_BUSY] = 1'b1; e[O_MULT] = 1'b1;
            n_checks++;
            if (outs !== e) $display("FAIL pre_reset_mult cyc=%0d got=%b exp=%b", k, outs, e);
            else n_pass++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (outs !== 14'b0) $display("FAIL reset_mid got=%b exp=%b", outs, 14'b0);
        else n_pass++;
        for (int k = 12; k <= 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 14'b0) $display("FAIL abandoned_mult cyc=%0d got=%b exp=%b", k, outs, 14'b0);
            else n_pass++;
        end
        test_div();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_reserved(2'b11);
`ifdef MD_DIVM_EN
        test_divm(1'b0);
        test_divm(1'b1);
`else
        test_reserved(2'b10);
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
